// File: rtl/m_cp0_unit.sv
// Coprocessor-0 for the M stage: SR, Cause, EPC and PRId, mtc0/mfc0 access,
// exception/interrupt request generation and victim-PC capture.
module m_cp0_unit #(
    parameter logic [31:0] PRID_VAL = 32'h0000_0007,
    parameter logic [4:0]  EXC_INT  = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CP0WrEn,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        unused_cp0in;

    assign unused_cp0in = ^{CP0In[31:16], CP0In[9:2]};

    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    assign Req     = int_req | exc_req;

    assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};
    assign EPCOut    = epc_q;

    always_comb begin
        case (CP0Addr)
            ADDR_SR:    CP0Out = sr_val;
            ADDR_CAUSE: CP0Out = cause_val;
            ADDR_EPC:   CP0Out = epc_q;
            ADDR_PRID:  CP0Out = PRID_VAL;
            default:    CP0Out = 32'b0;
        endcase
    end

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (Req) begin
            // The victim does not commit, so a concurrent mtc0 is dropped.
            exl_d     = 1'b1;
            exccode_d = int_req ? EXC_INT : ExcCodeIn;
            bd_d      = BDIn;
            epc_d     = BDIn ? (VPC - 32'd4) : VPC;
        end else begin
            if (CP0WrEn) begin
                case (CP0Addr)
                    ADDR_SR: begin
                        im_d  = CP0In[15:10];
                        exl_d = CP0In[1];
                        ie_d  = CP0In[0];
                    end
                    ADDR_EPC: epc_d = CP0In;
                    default: ;
                endcase
            end
            // eret wins over an mtc0 to SR for the EXL bit.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= 6'b0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'b0;
            exccode_q <= 5'b0;
            epc_q     <= 32'b0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end
endmodule

// File: tb/tb_m_cp0_unit.sv
// Directed bench for m_cp0_unit: reset, mtc0/mfc0, interrupt and exception
// entry, EXL blocking, eret, priority and asynchronous reset.
module tb_m_cp0_unit;
    logic        clk;
    logic        reset;
    logic        CP0WrEn;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int errors = 0;
    int checks = 0;

    m_cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .CP0WrEn   (CP0WrEn),
        .CP0Addr   (CP0Addr),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        CP0Addr = addr;
        #1;
        chk(tag, CP0Out, exp);
    endtask

    initial begin
        reset = 1'b1; CP0WrEn = 1'b0; CP0Addr = 5'd12; CP0In = 32'b0;
        VPC = 32'b0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'b0; EXLClr = 1'b0;
        #2;
        chk("rst_req", {31'b0, Req}, 32'd0);
        chk("rst_epcout", EPCOut, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        rd("sweep_sr", 5'd12, 32'h0);
        rd("sweep_cause", 5'd13, 32'h0);
        rd("sweep_epc", 5'd14, 32'h0);
        rd("sweep_prid", 5'd15, 32'h0000_0007);
        chk("idle_req", {31'b0, Req}, 32'd0);

        // Enable all interrupt lines, then raise HWInt[2].
        CP0WrEn = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_FC01;
        @(negedge clk);
        CP0WrEn = 1'b0;
        rd("sr_written", 5'd12, 32'h0000_FC01);
        HWInt = 6'b000100; VPC = 32'h0000_3008; BDIn = 1'b0;
        #1;
        chk("int_req_now", {31'b0, Req}, 32'd1);
        @(negedge clk);
        chk("int_epc", EPCOut, 32'h0000_3008);
        rd("int_cause", 5'd13, 32'h0000_1000);
        rd("int_sr_exl", 5'd12, 32'h0000_FC03);
        chk("int_req_blocked", {31'b0, Req}, 32'd0);

        HWInt = 6'b0; EXLClr = 1'b1;
        @(negedge clk);
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_FC01);

        // Exception in a delay slot with a concurrent mtc0 EPC.
        ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h0000_3010;
        CP0WrEn = 1'b1; CP0Addr = 5'd14; CP0In = 32'h1234_5678;
        #1;
        chk("exc_req_now", {31'b0, Req}, 32'd1);
        @(negedge clk);
        CP0WrEn = 1'b0; ExcCodeIn = 5'd0; BDIn = 1'b0;
        chk("exc_epc_bd", EPCOut, 32'h0000_300C);
        rd("exc_cause", 5'd13, 32'h8000_0028);

        // EXL set: nothing new is taken, IP still tracks the lines.
        ExcCodeIn = 5'd4; HWInt = 6'h3F;
        #1;
        chk("exl_blocks", {31'b0, Req}, 32'd0);
        @(negedge clk);
        ExcCodeIn = 5'd0;
        rd("exl_ip_follows", 5'd13, 32'h8000_FC28);
        EXLClr = 1'b1;
        #1;
        chk("eret_cycle_req", {31'b0, Req}, 32'd0);
        @(negedge clk);
        EXLClr = 1'b0;
        #1;
        chk("pending_int_req", {31'b0, Req}, 32'd1);
        rd("pending_sr", 5'd12, 32'h0000_FC01);

        // Interrupt beats a simultaneous exception.
        ExcCodeIn = 5'd12; VPC = 32'h0000_4000; BDIn = 1'b0;
        @(negedge clk);
        ExcCodeIn = 5'd0;
        rd("prio_cause", 5'd13, 32'h0000_FC00);
        chk("prio_epc", EPCOut, 32'h0000_4000);

        // mtc0 Cause is ignored; mtc0 SR with eret clears EXL.
        HWInt = 6'b0;
        CP0WrEn = 1'b1; CP0Addr = 5'd13; CP0In = 32'hFFFF_FFFF;
        @(negedge clk);
        CP0WrEn = 1'b0;
        rd("cause_ro", 5'd13, 32'h0000_0000);
        CP0WrEn = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_FC03; EXLClr = 1'b1;
        @(negedge clk);
        CP0WrEn = 1'b0; EXLClr = 1'b0;
        rd("sr_eret_wins", 5'd12, 32'h0000_FC01);
        rd("other_addr", 5'd5, 32'h0);

        // EPC wraps below zero for a delay-slot victim at PC 0.
        ExcCodeIn = 5'd8; BDIn = 1'b1; VPC = 32'h0;
        @(negedge clk);
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        chk("epc_wrap", EPCOut, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0020);

        // Asynchronous reset mid-handler, checked before the next edge.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        rd("arst_sr", 5'd12, 32'h0);
        rd("arst_cause", 5'd13, 32'h0);
        rd("arst_epc", 5'd14, 32'h0);
        chk("arst_epcout", EPCOut, 32'h0);
        chk("arst_req", {31'b0, Req}, 32'd0);
        rd("arst_prid", 5'd15, 32'h0000_0007);
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/m_cp0_unit.md
Name: m_cp0_unit

Overview:
- Coprocessor-0 for the M stage of the pipelined MIPS core.
- Holds SR, Cause, EPC and PRId.
- Services mtc0/mfc0, raises the exception/interrupt request that flushes the pipeline, and latches the victim PC.
- Its mfc0 read data is selected into M_RegData and flows into the W-stage pipeline register.

Parameters:
- PRID_VAL, 32'h0000_0007, constant value read from CP0 register 15.
- EXC_INT, 5'd0, ExcCode recorded for interrupts.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- CP0WrEn  input  1  mtc0 in M stage.
- CP0Addr  input  5  CP0 register number (12 SR, 13 Cause, 14 EPC, 15 PRId).
- CP0In  input  32  mtc0 write data.
- CP0Out  output  32  mfc0 read data; combinational from CP0Addr.
- VPC  input  32  PC of the instruction currently in M.
- BDIn  input  1  M instruction is in a branch delay slot.
- ExcCodeIn  input  5  exception code of M instruction; 0 = none.
- HWInt  input  6  external hardware interrupt lines.
- EXLClr  input  1  eret in M stage.
- EPCOut  output  32  current EPC, used as the eret target.
- Req  output  1  take exception/interrupt now; combinational.

Behaviour:
- State fields:
  - SR.IM[15:10], SR.EXL[1], SR.IE[0]; all other SR bits read 0.
  - Cause.BD[31], Cause.IP[15:10], Cause.ExcCode[6:2]; all other bits read 0.
  - EPC: 32 bits.
- Reset (asynchronous, active-high):
  - All fields clear to 0 immediately, independent of clk.
  - Consequences: CP0Out = 0 unless CP0Addr = 15; EPCOut = 0; Req = 0.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- Req = IntReq | ExcReq. No latency: asserted in the same cycle the condition exists.
- Priority: interrupt over exception. When IntReq = 1, the recorded ExcCode is EXC_INT regardless of ExcCodeIn.
- Cause.IP <= HWInt on every rising edge, including cycles where Req = 1. No masking applied.
- On a rising edge with Req = 1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= (IntReq ? EXC_INT : ExcCodeIn).
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? VPC-4 : VPC, using 32-bit unsigned wrap.
  - An mtc0 in the same cycle is ignored: the victim instruction does not commit.
- Else, on a rising edge with CP0WrEn = 1:
  - Addr 12: SR.IM/EXL/IE <= CP0In[15:10], [1], [0].
  - Addr 14: EPC <= CP0In.
  - Addr 13, Addr 15, other addresses: write ignored.
- EXLClr = 1 with Req = 0: SR.EXL <= 0 at the edge.
  - If the same cycle is also an mtc0 to SR, the EXL bit is taken from EXLClr (cleared). IM/IE still take CP0In.
- EXL = 1 blocks all new requests, interrupts and exceptions alike. Nested exceptions are not taken.
- CP0Out: addr 12/13/14 return the assembled register; addr 15 returns PRID_VAL; any other address returns 0.
  - Reads reflect pre-edge state; there is no write-to-read bypass within a cycle.
- Reset asserted mid-handler: EXL is cleared and EPC is lost. This is required behaviour.

Test Plan:
- Reset release, CP0Addr sweep 12..15 -> reads 0, 0, 0, 32'h0000_0007; Req = 0; EPCOut = 0.
- mtc0 SR <- 32'h0000_FC01, then HWInt = 6'b000100, VPC = 32'h0000_3008, BDIn = 0:
  - Req = 1 in the same cycle.
  - After the edge: EPC = 32'h0000_3008, Cause = 32'h0000_1000, SR.EXL = 1, Req = 0.
- ExcCodeIn = 5'd10, BDIn = 1, VPC = 32'h0000_3010, with mtc0 EPC <- 32'h1234_5678 in the same cycle:
  - Req = 1.
  - After the edge: EPC = 32'h0000_300C, Cause = 32'h8000_0028 (BD set, ExcCode 10); the mtc0 is discarded.
- With EXL = 1, pulse ExcCodeIn = 5'd4 and HWInt = 6'h3F -> Req stays 0; Cause.IP still follows HWInt.
  - Then EXLClr = 1 for one edge -> EXL = 0; pending interrupt raises Req immediately.
- Interrupt and ExcCodeIn = 5'd12 in the same cycle -> recorded ExcCode = 0.
- Assert reset asynchronously between edges while EXL = 1 -> SR, Cause, EPC read 0 before the next clk edge.
